// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB datapath; owns PC and IR.
// Latency: j 2, beq 3, R/addi/sw 4, lw 5 cycles (FETCH included); every output is registered.
// Backpressure: run is honoured only in FETCH; an instruction in flight always completes. Macro: MC_CTRL_RETIRE_CNT_EN.
module mc_ctrl_fsm #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0080,
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] ins,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic [2:0]  op,
    output logic        retire,
    output logic        halted,
    output logic        illegal
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] instr_cnt
`endif
);

    // Opcodes understood by the sequencer
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // ALU op encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Retire counter: full 32 bits when exported, otherwise just wide enough for the limit
`ifdef MC_CTRL_RETIRE_CNT_EN
    localparam int CNT_W = 32;
`else
    localparam int CNT_W = (MAX_INSTR == 0) ? 1 : $clog2(MAX_INSTR + 1);
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_INSTR - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_R,
        K_ADDI,
        K_LW,
        K_SW,
        K_BEQ,
        K_J,
        K_BAD
    } kind_t;

    state_t           state;
    kind_t            kind;
    kind_t            dec_kind;
    logic [2:0]       dec_op;
    logic [31:0]      ir;
    logic [31:0]      pc4;
    logic [31:0]      br_tgt;
    logic [31:0]      jmp_tgt;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    // Sequential next-PC candidates; all arithmetic wraps modulo 2^32
    assign pc4     = pc + 32'd4;
    assign br_tgt  = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    assign jmp_tgt = {pc4[31:28], ir[25:0], 2'b00};

    // The retire in progress is the one that reaches the instruction limit
    assign at_limit = (MAX_INSTR != 0) && (cnt == LAST_CNT);

`ifdef MC_CTRL_RETIRE_CNT_EN
    assign instr_cnt = cnt;
`endif

    // Classify the latched instruction by opcode
    always_comb begin
        dec_kind = K_BAD;
        case (ir[31:26])
            OPC_RTYPE: dec_kind = K_R;
            OPC_ADDI:  dec_kind = K_ADDI;
            OPC_LW:    dec_kind = K_LW;
            OPC_SW:    dec_kind = K_SW;
            OPC_BEQ:   dec_kind = K_BEQ;
            OPC_J:     dec_kind = K_J;
            default:   dec_kind = K_BAD;
        endcase
    end

    // ALU op for the latched instruction; unknown R-type functs fall back to add
    always_comb begin
        dec_op = ALU_ADD;
        case (dec_kind)
            K_R: begin
                case (ir[5:0])
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_ADD:  dec_op = ALU_ADD;
                    FN_SUB:  dec_op = ALU_SUB;
                    FN_SLT:  dec_op = ALU_SLT;
                    default: dec_op = ALU_ADD;
                endcase
            end
            K_BEQ:   dec_op = ALU_SUB;
            default: dec_op = ALU_ADD;
        endcase
    end

    // Control sequencer: retire is registered high exactly in an instruction's last state,
    // so it doubles as the "leaving the last state" marker for PC update and output clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            kind     <= K_R;
            ir       <= '0;
            pc       <= RESET_PC;
            cnt      <= '0;
            RegDst   <= 1'b0;
            RegWrite <= 1'b0;
            ALUSrc   <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            Mem2Reg  <= 1'b0;
            op       <= ALU_ADD;
            retire   <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        ir     <= ins;
                        state  <= S_DECODE;
                        // j finishes in DECODE, so its retire must be raised on the fetch edge
                        retire <= (ins[31:26] == OPC_J);
                    end
                end
                S_DECODE: begin
                    if (retire) begin
                        pc <= jmp_tgt;
                    end else if (dec_kind == K_BAD) begin
                        // PC stays on the offending instruction
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        kind    <= dec_kind;
                        state   <= S_EXEC;
                        RegDst  <= (dec_kind == K_R);
                        ALUSrc  <= (dec_kind == K_ADDI) || (dec_kind == K_LW) || (dec_kind == K_SW);
                        Mem2Reg <= (dec_kind == K_LW);
                        op      <= dec_op;
                        retire  <= (dec_kind == K_BEQ);
                    end
                end
                S_EXEC: begin
                    if (retire) begin
                        // beq: zero is the comparison result of this EXEC cycle
                        pc <= zero ? br_tgt : pc4;
                    end else if ((kind == K_LW) || (kind == K_SW)) begin
                        state    <= S_MEM;
                        MemRead  <= (kind == K_LW);
                        MemWrite <= (kind == K_SW);
                        retire   <= (kind == K_SW);
                    end else begin
                        state    <= S_WB;
                        RegWrite <= 1'b1;
                        retire   <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (retire) begin
                        pc <= pc4;
                    end else begin
                        // lw continues to writeback with the read still enabled
                        state    <= S_WB;
                        MemWrite <= 1'b0;
                        RegWrite <= 1'b1;
                        retire   <= 1'b1;
                    end
                end
                S_WB: begin
                    pc <= pc4;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase

            // Common retire epilogue: clear controls, count, and go back to FETCH or stop at the limit
            if (retire) begin
                RegDst   <= 1'b0;
                RegWrite <= 1'b0;
                ALUSrc   <= 1'b0;
                MemRead  <= 1'b0;
                MemWrite <= 1'b0;
                Mem2Reg  <= 1'b0;
                op       <= ALU_ADD;
                retire   <= 1'b0;
                cnt      <= cnt + CNT_W'(1);
                if (at_limit) begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end else begin
                    state  <= S_FETCH;
                end
            end
        end
    end

endmodule
